// File: rtl/legv8_imm_gen_pipe.sv
// legv8_imm_gen_pipe
//   Pipelined immediate generator for the LEGv8 decode stage. Extracts the immediate field
//   selected by i_fmt from a 32-bit instruction, sign/zero-extends it, scales it, and delivers
//   the result truncated to DATA_W bits through a one-entry valid/ready output buffer.
//
// Parameters
//   DATA_W   output width, 28..64 (result is built at 64 bits, low DATA_W bits are kept)
//   BR_SHIFT left shift applied to B and CB offsets (word to byte address)
//
// Ports
//   i_clk         rising-edge clock
//   i_reset       synchronous active-high reset
//   i_in_valid    i_instr/i_fmt valid this cycle
//   o_in_ready    block accepts input this cycle
//   i_instr       instruction word
//   i_fmt         0=D, 1=I, 2=B, 3=CB, 4=IW, 5..7 illegal
//   o_out_valid   o_imm_out holds a result
//   i_out_ready   consumer takes the result this cycle
//   o_imm_out     extended immediate
//   o_out_illegal result came from an illegal format
//   o_err_count   saturating count of accepted illegal formats
//                 (present only when LEGV8_IMM_ERRCNT_EN is defined)
//
// Optional feature macro: LEGV8_IMM_ERRCNT_EN
module legv8_imm_gen_pipe #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [31:0]       i_instr,
  input  logic [2:0]        i_fmt,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_imm_out,
  output logic              o_out_illegal
`ifdef LEGV8_IMM_ERRCNT_EN
  ,
  output logic [7:0]        o_err_count
`endif
);

  localparam logic [2:0] FMT_D  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_B  = 3'd2;
  localparam logic [2:0] FMT_CB = 3'd3;
  localparam logic [2:0] FMT_IW = 3'd4;

  logic [63:0]       w_imm64;
  logic              w_illegal;
  logic              w_accept;
  logic              w_unused_instr;

  logic              r_out_valid;
  logic [DATA_W-1:0] r_imm;
  logic              r_illegal;

  // Opcode bits never carry immediate data.
  assign w_unused_instr = ^i_instr[31:26];

  // All extension and shifting happens at 64 bits; bits pushed past bit 63 are dropped.
  always_comb begin
    w_imm64   = '0;
    w_illegal = 1'b0;
    case (i_fmt)
      FMT_D:   w_imm64 = {{55{i_instr[20]}}, i_instr[20:12]};
      FMT_I:   w_imm64 = {52'd0, i_instr[21:10]};
      FMT_B:   w_imm64 = {{38{i_instr[25]}}, i_instr[25:0]} << BR_SHIFT;
      FMT_CB:  w_imm64 = {{45{i_instr[23]}}, i_instr[23:5]} << BR_SHIFT;
      FMT_IW:  w_imm64 = {48'd0, i_instr[20:5]} << {i_instr[22:21], 4'b0000};
      default: w_illegal = 1'b1;
    endcase
  end

  if (DATA_W < 64) begin : g_trunc
    logic w_unused_hi;
    assign w_unused_hi = ^w_imm64[63:DATA_W];
  end

  // Ready is held low while reset is asserted so nothing is captured in the reset cycle.
  assign o_in_ready = ~i_reset & (~r_out_valid | i_out_ready);
  assign w_accept   = i_in_valid & o_in_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      // Covers both a fresh load and a simultaneous emit+load.
      r_out_valid <= 1'b1;
      r_imm       <= w_imm64[DATA_W-1:0];
      r_illegal   <= w_illegal;
    end else if (i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_imm_out     = r_imm;
  assign o_out_illegal = r_illegal;

`ifdef LEGV8_IMM_ERRCNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_err_count <= 8'd0;
    end else if (w_accept && w_illegal && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign o_err_count = r_err_count;
`endif

endmodule

// File: tb/tb_legv8_imm_gen_pipe.sv
module tb_legv8_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  fmt;

  logic        in_ready, out_valid, ill;
  logic [63:0] imm;
  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
`ifdef LEGV8_IMM_ERRCNT_EN
  logic [7:0]  errc, errc32;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [63:0] e64;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] ins;
    logic [2:0]  f;
    logic [63:0] e;
  } vec_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  legv8_imm_gen_pipe #(.DATA_W(64), .BR_SHIFT(2)) u_dut64 (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_instr      (instr),
    .i_fmt        (fmt),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_imm_out    (imm),
    .o_out_illegal(ill)
`ifdef LEGV8_IMM_ERRCNT_EN
    ,
    .o_err_count  (errc)
`endif
  );

  legv8_imm_gen_pipe #(.DATA_W(32), .BR_SHIFT(2)) u_dut32 (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready32),
    .i_instr      (instr),
    .i_fmt        (fmt),
    .o_out_valid  (out_valid32),
    .i_out_ready  (out_ready),
    .o_imm_out    (imm32),
    .o_out_illegal(ill32)
`ifdef LEGV8_IMM_ERRCNT_EN
    ,
    .o_err_count  (errc32)
`endif
  );

  // Reference model of the immediate, written with signed arithmetic.
  function automatic void model(input logic [31:0] ins, input logic [2:0] f,
                                output logic [63:0] e, output logic il);
    logic signed [63:0] s;
    e  = '0;
    il = 1'b0;
    case (f)
      3'd0: begin s = $signed(ins[20:12]); e = s; end
      3'd1: e = 64'(ins[21:10]);
      3'd2: begin s = $signed(ins[25:0]); e = s <<< 2; end
      3'd3: begin s = $signed(ins[23:5]); e = s <<< 2; end
      3'd4: e = 64'(ins[20:5]) << (16 * int'(ins[22:21]));
      default: il = 1'b1;
    endcase
  endfunction

  // Drives one cycle starting just after a falling edge, keeps the scoreboard in step with
  // accept/emit, and returns at the next falling edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] f,
                       input logic ordy, input logic [63:0] e, input logic eill);
    exp_t x;
    in_valid  = v;
    instr     = ins;
    fmt       = f;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready && sb.size() > 0) x = sb.pop_front();
    if (in_valid && in_ready) begin
      x.e64 = e;
      x.ill = eill;
      sb.push_back(x);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; instr = 32'hFFFF_FFFF; fmt = 3'd0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || imm !== 64'd0 || ill !== 1'b0 || in_ready !== 1'b0 ||
          out_valid32 !== 1'b0 || imm32 !== 32'd0)
        $display("FAIL reset[%0d]: valid=%b imm=%h ill=%b in_ready=%b, required 0/0/0/0",
                 c, out_valid, imm, ill, in_ready);
      else n_pass++;
    end
    rst = 1'b0;
    sb.delete();
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b valid=%b, required 1/0", in_ready, out_valid);
    else n_pass++;
    drive(1'b1, 32'h001F_4000, 3'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || imm !== 64'hFFFF_FFFF_FFFF_FFF4 || imm32 !== 32'hFFFF_FFF4)
      $display("FAIL first_result: valid=%b imm=%h imm32=%h, required 1/fffffffffffffff4",
               out_valid, imm, imm32);
    else n_pass++;
    drive(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || sb.size() != 0)
      $display("FAIL emit_clear: valid=%b pending=%0d, required 0/0", out_valid, sb.size());
    else n_pass++;
  endtask

  task automatic test_ext_scale();
    vec_t tbl[8];
    tbl[0] = '{32'h001F_4000, 3'd0, 64'hFFFF_FFFF_FFFF_FFF4};
    tbl[1] = '{32'h003F_FC00, 3'd1, 64'h0000_0000_0000_0FFF};
    tbl[2] = '{32'hFFE0_0FFF, 3'd0, 64'h0};
    tbl[3] = '{32'hFFC0_03FF, 3'd1, 64'h0};
    tbl[4] = '{32'h03FF_FFFF, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC};
    tbl[5] = '{32'h0000_0200, 3'd3, 64'h0000_0000_0000_0040};
    tbl[6] = '{32'h01FF_FFFF, 3'd2, 64'h0000_0000_07FF_FFFC};
    tbl[7] = '{32'h0080_0000, 3'd3, 64'hFFFF_FFFF_FFF0_0000};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].ins, tbl[i].f, 1'b1, tbl[i].e, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0 || imm !== sb[0].e64 ||
          imm32 !== sb[0].e64[31:0] || ill !== 1'b0 || out_valid32 !== 1'b1)
        $display("FAIL ext[%0d]: valid=%b imm=%h imm32=%h ill=%b, required valid=1 imm=%h",
                 i, out_valid, imm, imm32, ill, tbl[i].e);
      else n_pass++;
    end
    drive(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
  endtask

  task automatic test_iw();
    vec_t tbl[3];
    tbl[0] = '{32'h0057_DDE0, 3'd4, 64'h0000_BEEF_0000_0000};
    tbl[1] = '{32'hFF97_DDE0, 3'd4, 64'h0000_0000_0000_BEEF};
    tbl[2] = '{32'h0070_0020, 3'd4, 64'h8001_0000_0000_0000};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, tbl[i].ins, tbl[i].f, 1'b1, tbl[i].e, 1'b0);
      n_checks++;
      if (out_valid !== 1'b1 || sb.size() == 0 || imm !== sb[0].e64 ||
          imm32 !== tbl[i].e[31:0] || ill !== 1'b0 || ill32 !== 1'b0)
        $display("FAIL iw[%0d]: valid=%b imm=%h imm32=%h, required imm=%h",
                 i, out_valid, imm, imm32, tbl[i].e);
      else n_pass++;
    end
    drive(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
  endtask

  task automatic test_backpressure();
    drive(1'b1, 32'h001F_4000, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0);
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 32'h003F_FC00 ^ (c << 26), 3'd1, 1'b0, 64'h0FFF, 1'b0);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || imm !== 64'hFFFF_FFFF_FFFF_FFF4 ||
          ill !== 1'b0 || in_ready32 !== 1'b0 || imm32 !== 32'hFFFF_FFF4)
        $display("FAIL hold[%0d]: in_ready=%b valid=%b imm=%h, required 0/1/fffffffffffffff4",
                 c, in_ready, out_valid, imm);
      else n_pass++;
    end
    drive(1'b1, 32'h003F_FC00, 3'd1, 1'b1, 64'h0FFF, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || imm !== 64'h0FFF || sb.size() != 1)
      $display("FAIL emit_accept: valid=%b imm=%h pending=%0d, required 1/fff/1",
               out_valid, imm, sb.size());
    else n_pass++;
    drive(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || sb.size() != 0)
      $display("FAIL bp_drain: valid=%b pending=%0d, required 0/0", out_valid, sb.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 32'h03FF_FFFF, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
      n_checks++;
      if (out_valid !== 1'b0 || imm !== 64'd0)
        $display("FAIL mid_reset[%0d]: valid=%b imm=%h, required 0/0", c, out_valid, imm);
      else n_pass++;
    end
  endtask

  task automatic test_illegal();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, $urandom, 3'd6, 1'b1, 64'd0, 1'b1);
      n_checks++;
      if (out_valid !== 1'b1 || imm !== 64'd0 || ill !== 1'b1 || imm32 !== 32'd0 || ill32 !== 1'b1)
        $display("FAIL illegal[%0d]: valid=%b imm=%h ill=%b, required 1/0/1",
                 i, out_valid, imm, ill);
      else n_pass++;
    end
    drive(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
`ifdef LEGV8_IMM_ERRCNT_EN
    n_checks++;
    if (errc !== 8'd3 || errc32 !== 8'd3)
      $display("FAIL errcnt3: count=%0d, required 3", errc);
    else n_pass++;
    for (int i = 0; i < 300; i++) drive(1'b1, $urandom, 3'd5 + 3'(i % 3), 1'b1, 64'd0, 1'b1);
    drive(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
    n_checks++;
    if (errc !== 8'hFF || errc32 !== 8'hFF)
      $display("FAIL errcnt_sat: count=%h, required ff", errc);
    else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [63:0] e, prev_imm;
    logic        il, v, r, prev_hold;
    logic [31:0] ins;
    logic [2:0]  f;
    prev_hold = 1'b0;
    prev_imm  = '0;
    for (int i = 0; i < 80; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 2) != 0);
      ins = $urandom;
      f   = 3'($urandom_range(0, 7));
      model(ins, f, e, il);
      prev_hold = out_valid & ~r;
      prev_imm  = imm;
      drive(v, ins, f, r, e, il);
      if (prev_hold) begin
        n_checks++;
        if (out_valid !== 1'b1 || imm !== prev_imm)
          $display("FAIL rnd_hold[%0d]: valid=%b imm=%h, required 1/%h", i, out_valid, imm, prev_imm);
        else n_pass++;
      end
      if (out_valid === 1'b1) begin
        n_checks++;
        if (sb.size() == 0 || imm !== sb[0].e64 || imm32 !== sb[0].e64[31:0] ||
            ill !== sb[0].ill || ill32 !== sb[0].ill)
          $display("FAIL rnd[%0d]: imm=%h imm32=%h ill=%b pending=%0d, required %h/%b",
                   i, imm, imm32, ill, sb.size(),
                   (sb.size() > 0) ? sb[0].e64 : 64'd0, (sb.size() > 0) ? sb[0].ill : 1'b0);
        else n_pass++;
      end
    end
    for (int c = 0; c < 3 && (out_valid === 1'b1); c++) drive(1'b0, 32'd0, 3'd0, 1'b1, 64'd0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b0 || sb.size() != 0)
      $display("FAIL rnd_drain: valid=%b pending=%0d, required 0/0", out_valid, sb.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instr = '0; fmt = '0;
    @(negedge clk);
    test_reset();
    test_ext_scale();
    test_iw();
    test_backpressure();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
